vote_tally_seq: RTL and testbench



---
 rtl/vote_tally_seq.sv | 124 ++++++++++++
 tb/tb_vote_tally_seq.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/vote_tally_seq.sv
// vote_tally_seq: sequential voting session over N voter channels.
// A session starts on START in IDLE. Each voter may cast one ballot per session.
// Collection ends when every voter has cast, or when the timeout window expires.
// A registered PASS and a one-cycle DONE pulse then report the result.
// Optional build macro VOTE_TALLY_EARLY_DECIDE_EN: collection also ends as soon as
// the outcome can no longer change.
module vote_tally_seq #(
  parameter int N  = 7,
  parameter int CW = $clog2(N + 1),
  parameter int TW = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic [CW-1:0] THRESH,
  input  logic [TW-1:0] TIMEOUT,
  input  logic [N-1:0]  VALID,
  input  logic [N-1:0]  VOTE,
  output logic          BUSY,
  output logic          DONE,
  output logic          PASS,
  output logic [CW-1:0] YES_CNT,
  output logic [CW-1:0] VOTED_CNT
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_DECIDE  = 2'd2;

  logic [1:0]    r_state;
  logic [N-1:0]  r_cast;
  logic [CW-1:0] r_thresh;
  logic [TW-1:0] r_timer;
  logic [CW-1:0] r_yes;
  logic [CW-1:0] r_voted;
  logic          r_pass;
  logic          r_done;

  logic [N-1:0]  w_accept;
  logic [N-1:0]  w_cast_next;
  logic [CW-1:0] w_yes_next;
  logic [CW-1:0] w_voted_next;
  logic          w_all_cast;
  logic          w_timeout;
  logic          w_exit;

  // Counts fit in CW bits because a session never accepts more than N ballots.
  function automatic logic [CW-1:0] popcnt(input logic [N-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++) c = c + CW'(v[i]);
    return c;
  endfunction

  // A ballot is accepted only from voters that have not yet cast in this session.
  assign w_accept     = VALID & ~r_cast;
  assign w_cast_next  = r_cast | w_accept;
  assign w_yes_next   = r_yes + popcnt(w_accept & VOTE);
  assign w_voted_next = r_voted + popcnt(w_accept);
  assign w_all_cast   = &w_cast_next;
  // A timer value of 1 marks the last cycle of the window.
  // Ballots accepted in that cycle still count.
  assign w_timeout    = (r_timer == TW'(1));

`ifdef VOTE_TALLY_EARLY_DECIDE_EN
  logic [CW:0] w_reach;
  logic        w_early;
  // Best achievable yes count: current yes ballots plus every voter still outstanding.
  assign w_reach = {1'b0, w_yes_next} + ({1'b0, CW'(N)} - {1'b0, w_voted_next});
  assign w_early = (w_yes_next >= r_thresh) || (w_reach < {1'b0, r_thresh});
  assign w_exit  = w_all_cast || w_timeout || w_early;
`else
  assign w_exit  = w_all_cast || w_timeout;
`endif

  assign BUSY      = (r_state != S_IDLE);
  assign DONE      = r_done;
  assign PASS      = r_pass;
  assign YES_CNT   = r_yes;
  assign VOTED_CNT = r_voted;

  // Session FSM: latch on START, tally in COLLECT, register the verdict in DECIDE.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= S_IDLE;
      r_cast   <= '0;
      r_thresh <= '0;
      r_timer  <= '0;
      r_yes    <= '0;
      r_voted  <= '0;
      r_pass   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (START) begin
            r_thresh <= THRESH;
            r_timer  <= TIMEOUT;
            r_cast   <= '0;
            r_yes    <= '0;
            r_voted  <= '0;
            r_pass   <= 1'b0;
            r_state  <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          r_cast  <= w_cast_next;
          r_yes   <= w_yes_next;
          r_voted <= w_voted_next;
          if (r_timer != '0) r_timer <= r_timer - TW'(1);
          if (w_exit) r_state <= S_DECIDE;
        end
        S_DECIDE: begin
          r_pass  <= (r_yes >= r_thresh);
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vote_tally_seq.sv
// Directed bench for vote_tally_seq (N=7 main instance, N=4 instance for THRESH>N).
module tb_vote_tally_seq;

`ifdef VOTE_TALLY_EARLY_DECIDE_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [2:0] thresh = '0;
  logic [7:0] timeout = '0;
  logic [6:0] valid = '0;
  logic [6:0] vote = '0;
  logic       busy, done, pass;
  logic [2:0] yes_cnt, voted_cnt;

  logic       start4 = 1'b0;
  logic [3:0] valid4 = '0;
  logic [3:0] vote4 = '0;
  logic       busy4, done4, pass4;
  logic [2:0] yes4, voted4;

  int n_cmp = 0;
  int n_err = 0;

  vote_tally_seq #(.N(7)) u_dut (
    .CLK(clk), .RST(rst), .START(start), .THRESH(thresh), .TIMEOUT(timeout),
    .VALID(valid), .VOTE(vote), .BUSY(busy), .DONE(done), .PASS(pass),
    .YES_CNT(yes_cnt), .VOTED_CNT(voted_cnt)
  );

  vote_tally_seq #(.N(4)) u_dut4 (
    .CLK(clk), .RST(rst), .START(start4), .THRESH(thresh), .TIMEOUT(timeout),
    .VALID(valid4), .VOTE(vote4), .BUSY(busy4), .DONE(done4), .PASS(pass4),
    .YES_CNT(yes4), .VOTED_CNT(voted4)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (actual running, required finished)");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0] th;
    logic [6:0] vt;
    logic [2:0] yes;
    logic       ps;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; the next rising edge samples them.
  task automatic start_session(input logic [2:0] th, input logic [7:0] to);
    @(negedge clk);
    start = 1'b1; thresh = th; timeout = to;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic ballot(input logic [6:0] v, input logic [6:0] b);
    valid = v; vote = b;
    @(negedge clk);
    valid = '0; vote = '0;
  endtask

  // Counts the falling edges until DONE is seen, up to a bound.
  task automatic wait_done(input int max, output int n);
    n = 0;
    while (!done && n < max) begin
      @(negedge clk);
      n++;
    end
  endtask

  int  n;
  logic seen;

  initial begin
    tbl[0] = '{th: 3'd4, vt: 7'b0001111, yes: 3'd4, ps: 1'b1};
    tbl[1] = '{th: 3'd4, vt: 7'b0000111, yes: 3'd3, ps: 1'b0};
    tbl[2] = '{th: 3'd0, vt: 7'b0000000, yes: 3'd0, ps: 1'b1};
    tbl[3] = '{th: 3'd7, vt: 7'b1111111, yes: 3'd7, ps: 1'b1};
    tbl[4] = '{th: 3'd7, vt: 7'b0111111, yes: 3'd6, ps: 1'b0};
    tbl[5] = '{th: 3'd1, vt: 7'b1000000, yes: 3'd1, ps: 1'b1};

    // Reset state
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_yes", yes_cnt, 0);
    chk("rst_voted", voted_cnt, 0);
    @(negedge clk);
    rst = 1'b0;

    // Single-cycle sessions: every voter casts at once, TIMEOUT=0
    for (int i = 0; i < 6; i++) begin
      start_session(tbl[i].th, 8'd0);
      chk("tbl_busy", busy, 1);
      ballot(7'h7f, tbl[i].vt);
      wait_done(6, n);
      chk("tbl_latency", n, 1);
      chk("tbl_yes", yes_cnt, tbl[i].yes);
      chk("tbl_voted", voted_cnt, 7);
      chk("tbl_pass", pass, tbl[i].ps);
      @(negedge clk);
      chk("tbl_done_pulse", done, 0);
      chk("tbl_idle", busy, 0);
    end

    // Repeat ballots ignored (default build only: early exit would cut this short)
    if (!EARLY) begin
      start_session(3'd4, 8'd0);
      ballot(7'b0000001, 7'b0000001);
      ballot(7'b0000001, 7'b0000001);
      ballot(7'b0000001, 7'b0000001);
      chk("rep_yes_mid", yes_cnt, 1);
      chk("rep_voted_mid", voted_cnt, 1);
      for (int i = 1; i < 7; i++) begin
        ballot(7'(1 << i), 7'b0);
      end
      wait_done(6, n);
      chk("rep_latency", n, 1);
      chk("rep_yes", yes_cnt, 1);
      chk("rep_voted", voted_cnt, 7);
      chk("rep_pass", pass, 0);
    end

    // Timeout window of 5; START while busy is ignored; late ballot ignored
    start_session(3'd2, 8'd5);
    ballot(7'b0, 7'b0);
    start = 1'b1; thresh = 3'd7; timeout = 8'd1;
    ballot(7'b0, 7'b0);
    start = 1'b0;
    chk("to_busy_c2", busy, 1);
    ballot(7'b0, 7'b0);
    ballot(7'b0, 7'b0);
    chk("to_done_early", done, 0);
    chk("to_busy_c4", busy, 1);
    ballot(7'b0000011, 7'b0000011);
    ballot(7'b0000100, 7'b0000100);
    chk("to_done", done, 1);
    chk("to_yes", yes_cnt, 2);
    chk("to_voted", voted_cnt, 2);
    chk("to_pass", pass, 1);

    // THRESH=0 with no ballots passes
    start_session(3'd0, 8'd3);
    wait_done(12, n);
    chk("t0_latency", n, EARLY ? 2 : 4);
    chk("t0_done", done, 1);
    chk("t0_pass", pass, 1);
    chk("t0_voted", voted_cnt, 0);

    // START in the DONE cycle is accepted
    start = 1'b1; thresh = 3'd3; timeout = 8'd0;
    @(negedge clk);
    start = 1'b0;
    chk("sd_busy", busy, 1);
    chk("sd_pass_clear", pass, 0);
    ballot(7'h7f, 7'b0000111);
    wait_done(6, n);
    chk("sd_latency", n, 1);
    chk("sd_pass", pass, 1);

    // THRESH > N fails (N=4 instance)
    @(negedge clk);
    start4 = 1'b1; thresh = 3'd5; timeout = 8'd0;
    @(negedge clk);
    start4 = 1'b0; valid4 = 4'hf; vote4 = 4'hf;
    @(negedge clk);
    valid4 = '0; vote4 = '0;
    n = 0;
    while (!done4 && n < 6) begin
      @(negedge clk);
      n++;
    end
    chk("big_done", done4, 1);
    chk("big_yes", yes4, 4);
    chk("big_pass", pass4, 0);

    // Reset mid-session discards the tally
    start_session(3'd4, 8'd0);
    ballot(7'b0000111, 7'b0000101);
    chk("mr_yes", yes_cnt, 2);
    chk("mr_voted", voted_cnt, 3);
    #2 rst = 1'b1;
    #1;
    chk("mr_busy", busy, 0);
    chk("mr_yes0", yes_cnt, 0);
    chk("mr_voted0", voted_cnt, 0);
    chk("mr_pass0", pass, 0);
    #1 rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    chk("mr_no_done", seen, 0);
    start_session(3'd4, 8'd0);
    ballot(7'h7f, 7'b0001111);
    wait_done(6, n);
    chk("mr_new_latency", n, 1);
    chk("mr_new_yes", yes_cnt, 4);
    chk("mr_new_pass", pass, 1);

`ifdef VOTE_TALLY_EARLY_DECIDE_EN
    // Outcome fixed after two yes ballots
    @(negedge clk);
    start_session(3'd2, 8'd0);
    ballot(7'b0000011, 7'b0000011);
    wait_done(6, n);
    chk("early_latency", n, 1);
    chk("early_voted", voted_cnt, 2);
    chk("early_pass", pass, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
